// File: rtl/nn_avl_read_arbiter_if.sv
// nn_avl_read_arbiter_if: requester, controller and status signals of the
// two-port Avalon read arbiter. The slave modport is the arbiter's view and
// the master modport is the view of whatever drives the requesters/controller.
interface nn_avl_read_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 64,
    parameter int SIZE_W = 3
);
    // Requester 0 (cache fill)
    logic              req0_read;
    logic [ADDR_W-1:0] req0_addr;
    logic [SIZE_W-1:0] req0_size;
    logic              req0_ack;
    logic [DATA_W-1:0] req0_rdata;
    logic              req0_rdata_valid;
    // Requester 1 (display fetch)
    logic              req1_read;
    logic [ADDR_W-1:0] req1_addr;
    logic [SIZE_W-1:0] req1_size;
    logic              req1_ack;
    logic [DATA_W-1:0] req1_rdata;
    logic              req1_rdata_valid;
    // Controller command and return path
    logic              avl_ready;
    logic              avl_read_req;
    logic [ADDR_W-1:0] avl_addr;
    logic [SIZE_W-1:0] avl_size;
    logic [DATA_W-1:0] avl_rdata;
    logic              avl_rdata_valid;
    // Status and debug (dbg_state: 0 = IDLE, 1 = ISSUE)
    logic              err_orphan;
    logic              dbg_state;

    modport slave (
        input  req0_read, req0_addr, req0_size,
        input  req1_read, req1_addr, req1_size,
        input  avl_ready, avl_rdata, avl_rdata_valid,
        output req0_ack, req0_rdata, req0_rdata_valid,
        output req1_ack, req1_rdata, req1_rdata_valid,
        output avl_read_req, avl_addr, avl_size,
        output err_orphan, dbg_state
    );

    modport master (
        output req0_read, req0_addr, req0_size,
        output req1_read, req1_addr, req1_size,
        output avl_ready, avl_rdata, avl_rdata_valid,
        input  req0_ack, req0_rdata, req0_rdata_valid,
        input  req1_ack, req1_rdata, req1_rdata_valid,
        input  avl_read_req, avl_addr, avl_size,
        input  err_orphan, dbg_state
    );
endinterface

// File: rtl/nn_avl_read_arbiter.sv
// nn_avl_read_arbiter: round-robin read arbiter for two requesters in front
// of the DDR2 controller's Avalon read port. Accepted bursts are tracked in an
// in-order tag FIFO so returned beats are steered to the issuing requester.
// Optional macro NN_ARB_PERF_EN adds saturating perf counters
// (perf_grant0, perf_grant1, perf_stall).
//
// Handshakes: a command transfers on a clock edge where avl_read_req and
// avl_ready are both high; until then avl_addr/avl_size are held stable.
// A requester holds reqN_read/addr/size until reqN_ack (a one-cycle pulse
// the cycle after transfer). Return beats carry no back-pressure: every
// avl_rdata_valid beat is consumed on the edge it is presented.
module nn_avl_read_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 64,
    parameter int SIZE_W  = 3,
    parameter int MAX_OUT = 4
) (
    input  logic clk,
    input  logic reset,
`ifdef NN_ARB_PERF_EN
    output logic [15:0] perf_grant0,
    output logic [15:0] perf_grant1,
    output logic [15:0] perf_stall,
`endif
    nn_avl_read_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              gnt_id_q, gnt_id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic              last_grant_q, last_grant_d;
    logic              pick;
    logic [SIZE_W-1:0] sel_size;

    logic              ack0_q, ack1_q;
    logic              fifo_id_q   [MAX_OUT];
    logic [SIZE_W-1:0] fifo_size_q [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [SIZE_W-1:0] beat_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              rv0_q, rv1_q;
    logic              err_q;

    logic              push, pop, beat_ok, head_id;
    logic [SIZE_W-1:0] head_size, beat_inc;

    assign push      = (state_q == ISSUE) && bus.avl_ready;
    assign head_id   = fifo_id_q[rd_ptr_q];
    assign head_size = fifo_size_q[rd_ptr_q];
    assign beat_ok   = bus.avl_rdata_valid && (count_q != '0);
    assign beat_inc  = beat_q + SIZE_W'(1);
    assign pop       = beat_ok && (beat_inc == head_size);

    // Next-state logic: round-robin grant in IDLE (registered count, so a pop
    // on the same edge does not unblock a full FIFO), hold command in ISSUE.
    always_comb begin
        state_d      = state_q;
        gnt_id_d     = gnt_id_q;
        addr_d       = addr_q;
        size_d       = size_q;
        last_grant_d = last_grant_q;
        pick         = 1'b0;
        sel_size     = '0;
        case (state_q)
            IDLE: begin
                if ((count_q < MAX_CNT) && (bus.req0_read || bus.req1_read)) begin
                    if (bus.req0_read && bus.req1_read) pick = ~last_grant_q;
                    else                                pick = bus.req1_read;
                    sel_size = pick ? bus.req1_size : bus.req0_size;
                    gnt_id_d = pick;
                    addr_d   = pick ? bus.req1_addr : bus.req0_addr;
                    size_d   = (sel_size == '0) ? SIZE_W'(1) : sel_size;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.avl_ready) begin
                    last_grant_d = gnt_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, latched command and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_id_q     <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_id_q     <= gnt_id_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            last_grant_q <= last_grant_d;
            ack0_q       <= push && !gnt_id_q;
            ack1_q       <= push && gnt_id_q;
        end
    end

    // Tag FIFO: push {id, size} on command accept, pop on the last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                fifo_id_q[i]   <= 1'b0;
                fifo_size_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_id_q[wr_ptr_q]   <= gnt_id_q;
                fifo_size_q[wr_ptr_q] <= size_q;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Return path: count beats of the head burst, steer data, flag orphans.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (beat_ok) beat_q <= pop ? '0 : beat_inc;
            rv0_q <= beat_ok && !head_id;
            rv1_q <= beat_ok && head_id;
            if (beat_ok && !head_id) rdata0_q <= bus.avl_rdata;
            if (beat_ok && head_id)  rdata1_q <= bus.avl_rdata;
            if (bus.avl_rdata_valid && (count_q == '0)) err_q <= 1'b1;
        end
    end

`ifdef NN_ARB_PERF_EN
    logic [15:0] perf_grant0_q, perf_grant1_q, perf_stall_q;

    // Saturating counts of accepted commands per requester and stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grant0_q <= '0;
            perf_grant1_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (push && !gnt_id_q && (perf_grant0_q != 16'hFFFF))
                perf_grant0_q <= perf_grant0_q + 16'd1;
            if (push && gnt_id_q && (perf_grant1_q != 16'hFFFF))
                perf_grant1_q <= perf_grant1_q + 16'd1;
            if ((state_q == ISSUE) && !bus.avl_ready && (perf_stall_q != 16'hFFFF))
                perf_stall_q <= perf_stall_q + 16'd1;
        end
    end

    assign perf_grant0 = perf_grant0_q;
    assign perf_grant1 = perf_grant1_q;
    assign perf_stall  = perf_stall_q;
`endif

    assign bus.avl_read_req     = (state_q == ISSUE);
    assign bus.avl_addr         = addr_q;
    assign bus.avl_size         = size_q;
    assign bus.req0_ack         = ack0_q;
    assign bus.req1_ack         = ack1_q;
    assign bus.req0_rdata       = rdata0_q;
    assign bus.req1_rdata       = rdata1_q;
    assign bus.req0_rdata_valid = rv0_q;
    assign bus.req1_rdata_valid = rv1_q;
    assign bus.err_orphan       = err_q;
    assign bus.dbg_state        = (state_q == ISSUE);
endmodule

// File: doc/nn_avl_read_arbiter.md
Name: nn_avl_read_arbiter

Overview:
- Two-port read arbiter and scheduler in front of the DDR2 controller's Avalon read interface (avl_ready / avl_read_req / avl_rdata / avl_rdata_valid).
- Shares the controller between requester 0 (cache fill) and requester 1 (display fetch) using round-robin grant.
- Tracks outstanding bursts in an in-order tag FIFO so each returned beat is steered to the requester that issued it.
- Sits between the requesters and the controller, in the clk domain.

Parameters:
- ADDR_W, 25: address width.
- DATA_W, 64: read data width.
- SIZE_W, 3: burst-count width; legal counts are 1..2^SIZE_W-1.
- MAX_OUT, 4: maximum outstanding bursts (tag FIFO depth); a power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0_read  in  1  requester 0 read request; held until req0_ack.
- req0_addr  in  ADDR_W  requester 0 address.
- req0_size  in  SIZE_W  requester 0 burst count.
- req0_ack  out  1  one-cycle pulse: request accepted by controller.
- req0_rdata  out  DATA_W  returned data.
- req0_rdata_valid  out  1  beat valid for requester 0.
- req1_read, req1_addr, req1_size, req1_ack, req1_rdata, req1_rdata_valid: identical set for requester 1.
- avl_ready  in  1  controller can accept a command.
- avl_read_req  out  1  read command valid.
- avl_addr  out  ADDR_W  command address.
- avl_size  out  SIZE_W  command burst count.
- avl_rdata  in  DATA_W  read data from controller.
- avl_rdata_valid  in  1  read beat valid.
- err_orphan  out  1  sticky: a beat arrived while no burst was outstanding.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; beat counter 0; last_grant = 1, so requester 0 wins the first tie.
- FSM IDLE:
  - Grants only if FIFO count < MAX_OUT and at least one reqN_read is high.
  - Single requester: that requester is granted.
  - Both requesting: the one not equal to last_grant is granted.
  - On grant: register grant id, addr and size (size 0 promoted to 1); next state ISSUE.
- FSM ISSUE:
  - avl_read_req = 1; avl_addr / avl_size driven from the registered copies and held stable.
  - On the cycle avl_ready = 1: command accepted.
    - Push {id, size} into the FIFO.
    - Pulse reqN_ack for one cycle (registered, visible the next cycle).
    - last_grant <= id; next state IDLE.
  - If avl_ready = 0: stay in ISSUE; the command does not change.
- Latency: minimum 1 cycle from reqN_read high to avl_read_req high. Maximum command rate is one every 2 cycles.
- Requester obligation: hold reqN_read, addr and size until ack. Deasserting earlier is illegal; the latched copy is issued regardless.
- Return path:
  - Beats are in order. On avl_rdata_valid, the beat is steered to the FIFO head's id: reqN_rdata <= avl_rdata and reqN_rdata_valid <= 1, registered with 1-cycle latency. The other port's valid is 0.
  - Beat counter increments per beat. When it equals the head size: pop the FIFO and clear the counter.
- Simultaneous push and pop in the same cycle: count unchanged; both take effect.
- Full: with count == MAX_OUT, IDLE does not grant. A pop in the same cycle does not enable the grant until the next cycle.
- Orphan: avl_rdata_valid with the FIFO empty →
  - err_orphan <= 1 (sticky until reset);
  - the beat is dropped; no reqN_rdata_valid.
- Reset mid-operation clears the FSM, FIFO and counter. Beats arriving afterwards are orphans; the controller must be reset together with the arbiter.
- Widths: count is log2(MAX_OUT)+1 bits; beat counter is SIZE_W bits; read and write pointers wrap modulo MAX_OUT.

Optional Feature:
- Macro: NN_ARB_PERF_EN.
- When defined, these outputs are added:
  - perf_grant0 and perf_grant1, 16-bit saturating counts of accepted commands per requester;
  - perf_stall, 16-bit saturating count of cycles in ISSUE with avl_ready = 0.
- All counters clear on reset and hold at 16'hFFFF once reached.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single request: req0 addr=0x100, size=4, avl_ready=1. → avl_read_req high 1 cycle after request with addr 0x100, size 4; req0_ack 1 pulse. 4 beats D0..D3 appear on req0_rdata_valid with 1-cycle latency; req1_rdata_valid stays 0.
- Contention: req0 and req1 held high continuously after reset. → grants alternate 0,1,0,1 over 4 commands; each ack is exactly one cycle.
- Backpressure: avl_ready = 0 for 5 cycles during ISSUE. → addr and size stable all 5 cycles; ack only on the accept cycle. With NN_ARB_PERF_EN, perf_stall = 5.
- Full: MAX_OUT=4, issue 4 size-2 bursts with no returns. → 5th request not granted. After 2 beats return (pop), grant occurs the cycle after the pop.
- Interleaved return: bursts issued in order req1 (size 3) then req0 (size 1); 4 beats returned back-to-back. → first 3 beats go to req1, 4th to req0; push and pop in the same cycle keep the count correct.
- Orphan and reset: avl_rdata_valid with the FIFO empty → err_orphan = 1, no port valid. Reset pulse → err_orphan = 0, all outputs 0.
